// File: rtl/c64_dma_arbiter.sv
// c64_dma_arbiter: hands the C64 expansion bus to the HPS DMA master via /DMA and AEC, honouring VIC-II BA.
// Define DMA_ARB_STATS_EN to get a live grant_cycles counter and a grant_count output.
module c64_dma_arbiter #(
  parameter int unsigned BA_HOLDOFF_CYCLES = 3,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        phi2_in,
  input  logic        dma_req_n,
  input  logic        vic_ba_n,
  output logic        dma_ack,
  output logic        cpu_dma_n,
  output logic        aec_out,
  output logic [1:0]  bus_owner,
  output logic        phi2_fall,
  output logic        timeout_err,
`ifdef DMA_ARB_STATS_EN
  output logic [15:0] grant_cycles,
  output logic [15:0] grant_count
`else
  output logic [15:0] grant_cycles
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLDOFF = 3'd1;
  localparam logic [2:0] S_GRANTED = 3'd2;
  localparam logic [2:0] S_SUSPEND = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam int unsigned HW = (BA_HOLDOFF_CYCLES < 2) ? 1 : $clog2(BA_HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLDOFF_INIT = HW'(BA_HOLDOFF_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]    phi2Sync_q;
  logic [1:0]    vicSync_q;
  logic [2:0]    state_q, state_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic [31:0]   wdogCnt_q, wdogCnt_d;
  logic          lockout_q, lockout_d;
  logic          timeout_q, timeout_d;
  logic          dmaAck_q, dmaAck_d;
  logic          cpuDmaN_q, cpuDmaN_d;
  logic          aec_q, aec_d;
  logic [1:0]    owner_q, owner_d;
  logic          fallEvt, vicFree;
  logic          grantEntry, grantTick;

  // Bit 0 is the first synchronizer stage, bit 1 the second.
  assign fallEvt = phi2Sync_q[1] & ~phi2Sync_q[0];
  assign vicFree = vicSync_q[1];

  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    wdogCnt_d  = wdogCnt_q;
    lockout_d  = lockout_q;
    timeout_d  = 1'b0;
    grantEntry = 1'b0;
    grantTick  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dma_req_n) begin
          lockout_d = 1'b0;
        end else if (!lockout_q) begin
          state_d   = S_HOLDOFF;
          holdCnt_d = HOLDOFF_INIT;
        end
      end
      S_HOLDOFF: begin
        if (dma_req_n) begin
          state_d = S_RELEASE;
        end else if (fallEvt) begin
          if (holdCnt_q == '0) begin
            if (vicFree) begin
              state_d    = S_GRANTED;
              grantEntry = 1'b1;
              wdogCnt_d  = '0;
            end
          end else begin
            holdCnt_d = holdCnt_q - HW'(1);
          end
        end
      end
      S_GRANTED, S_SUSPEND: begin
        if (dma_req_n) begin
          state_d = S_RELEASE;
        end else if (fallEvt) begin
          grantTick = 1'b1;
          wdogCnt_d = wdogCnt_q + 32'd1;
          // The watchdog outranks a VIC-II suspend/resume on the same edge.
          if (WDOG_EN && (wdogCnt_d == 32'(TIMEOUT_CYCLES))) begin
            state_d   = S_RELEASE;
            timeout_d = 1'b1;
            lockout_d = 1'b1;
          end else if ((state_q == S_GRANTED) && !vicFree) begin
            state_d = S_SUSPEND;
          end else if ((state_q == S_SUSPEND) && vicFree) begin
            state_d = S_GRANTED;
          end
        end
      end
      S_RELEASE: begin
        if (fallEvt) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmaAck_d  = 1'b0;
    cpuDmaN_d = 1'b0;
    aec_d     = 1'b1;
    owner_d   = 2'd3;
    case (state_d)
      S_IDLE: begin
        cpuDmaN_d = 1'b1;
        owner_d   = 2'd0;
      end
      S_HOLDOFF: owner_d = 2'd1;
      S_GRANTED: begin
        dmaAck_d = 1'b1;
        aec_d    = 1'b0;
        owner_d  = 2'd2;
      end
      default: owner_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      phi2Sync_q <= 2'b00;
      vicSync_q  <= 2'b00;
      state_q    <= S_IDLE;
      holdCnt_q  <= '0;
      wdogCnt_q  <= '0;
      lockout_q  <= 1'b0;
      timeout_q  <= 1'b0;
      dmaAck_q   <= 1'b0;
      cpuDmaN_q  <= 1'b1;
      aec_q      <= 1'b1;
      owner_q    <= 2'd0;
    end else begin
      phi2Sync_q <= {phi2Sync_q[0], phi2_in};
      vicSync_q  <= {vicSync_q[0], vic_ba_n};
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      wdogCnt_q  <= wdogCnt_d;
      lockout_q  <= lockout_d;
      timeout_q  <= timeout_d;
      dmaAck_q   <= dmaAck_d;
      cpuDmaN_q  <= cpuDmaN_d;
      aec_q      <= aec_d;
      owner_q    <= owner_d;
    end
  end

  assign dma_ack     = dmaAck_q;
  assign cpu_dma_n   = cpuDmaN_q;
  assign aec_out     = aec_q;
  assign bus_owner   = owner_q;
  assign phi2_fall   = fallEvt;
  assign timeout_err = timeout_q;

`ifdef DMA_ARB_STATS_EN
  logic [15:0] grantCycles_q;
  logic [15:0] grantCount_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      grantCycles_q <= 16'h0000;
      grantCount_q  <= 16'h0000;
    end else begin
      if (grantEntry) begin
        grantCycles_q <= 16'h0000;
        grantCount_q  <= grantCount_q + 16'd1;
      end else if (grantTick && (grantCycles_q != 16'hFFFF)) begin
        grantCycles_q <= grantCycles_q + 16'd1;
      end
    end
  end

  assign grant_cycles = grantCycles_q;
  assign grant_count  = grantCount_q;
`else
  assign grant_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_c64_dma_arbiter.sv
// tb_c64_dma_arbiter: directed scenarios plus randomized traffic checked every clk against a behavioural model.
// Honours DMA_ARB_STATS_EN so grant_cycles/grant_count are checked in either build.
`timescale 1ns/1ps
module tb_c64_dma_arbiter;

  localparam int BA = 3;
  localparam int TO = 12;

  logic        clk_sys = 1'b0;
  logic        rst, phi2_in, dma_req_n, vic_ba_n;
  logic        dma_ack, cpu_dma_n, aec_out, phi2_fall, timeout_err;
  logic [1:0]  bus_owner;
  logic [15:0] grant_cycles;
`ifdef DMA_ARB_STATS_EN
  logic [15:0] grant_count;
`endif

  c64_dma_arbiter #(.BA_HOLDOFF_CYCLES(BA), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys(clk_sys), .rst(rst), .phi2_in(phi2_in), .dma_req_n(dma_req_n), .vic_ba_n(vic_ba_n),
    .dma_ack(dma_ack), .cpu_dma_n(cpu_dma_n), .aec_out(aec_out), .bus_owner(bus_owner),
    .phi2_fall(phi2_fall), .timeout_err(timeout_err),
`ifdef DMA_ARB_STATS_EN
    .grant_cycles(grant_cycles), .grant_count(grant_count)
`else
    .grant_cycles(grant_cycles)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: bus phase plus plain integer counters.
  localparam int M_IDLE = 0, M_HOLD = 1, M_GRANT = 2, M_SUSP = 3, M_REL = 4;
  int mMode, mHold, mWd, mGc, mGrants;
  bit mLock, mTmo, mP1, mP2, mV1, mV2, lastFall;
  int phiLeft;
  int tmoSeen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit reqN, input bit phi, input bit vic);
    bit fall, vicOk;
    if (r) begin
      mMode = M_IDLE; mHold = 0; mWd = 0; mGc = 0; mGrants = 0;
      mLock = 0; mTmo = 0; mP1 = 0; mP2 = 0; mV1 = 0; mV2 = 0; lastFall = 0;
      return;
    end
    fall  = mP2 && !mP1;
    vicOk = mV2;
    lastFall = fall;
    mTmo = 0;
    if (mMode == M_IDLE) begin
      if (reqN) mLock = 0;
      else if (!mLock) begin mMode = M_HOLD; mHold = BA; end
    end else if (mMode == M_HOLD) begin
      if (reqN) mMode = M_REL;
      else if (fall) begin
        if (mHold == 0 && vicOk) begin
          mMode = M_GRANT; mGc = 0; mWd = 0; mGrants = (mGrants + 1) % 65536;
        end
        if (mHold > 0) mHold = mHold - 1;
      end
    end else if (mMode == M_GRANT || mMode == M_SUSP) begin
      if (reqN) mMode = M_REL;
      else if (fall) begin
        if (mGc < 65535) mGc = mGc + 1;
        mWd = mWd + 1;
        if (TO != 0 && mWd >= TO) begin mMode = M_REL; mTmo = 1; mLock = 1; end
        else if (mMode == M_GRANT && !vicOk) mMode = M_SUSP;
        else if (mMode == M_SUSP && vicOk) mMode = M_GRANT;
      end
    end else begin
      if (fall) mMode = M_IDLE;
    end
    mP2 = mP1; mP1 = phi;
    mV2 = mV1; mV1 = vic;
  endtask

  function automatic bit grantOnNextEdge();
    return (mMode == M_HOLD) && (mHold == 0) && mP2 && !mP1 && mV2;
  endfunction

  // One clk: drive inputs, advance PHI2, step the model, then compare every output.
  task automatic applyStimulus(input bit r, input bit reqN, input bit vic);
    logic [1:0] expOwner;
    rst = r; dma_req_n = reqN; vic_ba_n = vic;
    phiLeft--;
    if (phiLeft <= 0) begin
      phi2_in = ~phi2_in;
      phiLeft = $urandom_range(2, 5);
    end
    @(posedge clk_sys);
    modelStep(r, reqN, phi2_in, vic);
    @(negedge clk_sys);
    case (mMode)
      M_IDLE:  expOwner = 2'd0;
      M_HOLD:  expOwner = 2'd1;
      M_GRANT: expOwner = 2'd2;
      default: expOwner = 2'd3;
    endcase
    checkOutput("dma_ack", 32'(dma_ack), 32'(mMode == M_GRANT));
    checkOutput("cpu_dma_n", 32'(cpu_dma_n), 32'(mMode == M_IDLE));
    checkOutput("aec_out", 32'(aec_out), 32'(mMode != M_GRANT));
    checkOutput("bus_owner", 32'(bus_owner), 32'(expOwner));
    checkOutput("phi2_fall", 32'(phi2_fall), 32'(mP2 && !mP1));
    checkOutput("timeout_err", 32'(timeout_err), 32'(mTmo));
    checkOutput("ackInvariant", 32'(dma_ack & (aec_out | cpu_dma_n)), 32'd0);
`ifdef DMA_ARB_STATS_EN
    checkOutput("grant_cycles", 32'(grant_cycles), 32'(mGc));
    checkOutput("grant_count", 32'(grant_count), 32'(mGrants));
`else
    checkOutput("grant_cycles", 32'(grant_cycles), 32'd0);
`endif
    if (timeout_err === 1'b1) tmoSeen++;
  endtask

  initial begin
    int falls, got, tmoBefore, ackHigh;
    int reqLeft, vicLeft;
    bit rq, vc;
    rst = 1'b1; dma_req_n = 1'b1; vic_ba_n = 1'b1; phi2_in = 1'b1; phiLeft = 3;
    modelStep(1'b1, 1'b1, 1'b1, 1'b1);

    repeat (3) applyStimulus(1, 1, 1);
    checkOutput("rstOwner", 32'(bus_owner), 32'd0);
    checkOutput("rstDmaN", 32'(cpu_dma_n), 32'd1);
    repeat (10) applyStimulus(0, 1, 1);

    // Basic grant: BA+1 falls from the request to the acknowledge.
    applyStimulus(0, 0, 1);
    checkOutput("reqDmaN", 32'(cpu_dma_n), 32'd0);
    falls = 0; got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      applyStimulus(0, 0, 1);
      if (lastFall) falls++;
      if (dma_ack === 1'b1) got = 1;
    end
    checkOutput("grantSeen", 32'(got), 32'd1);
    checkOutput("grantLatency", 32'(falls), 32'(BA + 1));

    // Release guard after 10 granted PHI2 cycles.
    falls = 0;
    for (int i = 0; i < 300 && falls < 10; i++) begin
      applyStimulus(0, 0, 1);
      if (lastFall) falls++;
    end
    checkOutput("tenFalls", 32'(falls), 32'd10);
`ifdef DMA_ARB_STATS_EN
    checkOutput("grantCycles10", 32'(grant_cycles), 32'd10);
`endif
    applyStimulus(0, 1, 1);
    checkOutput("relAck", 32'(dma_ack), 32'd0);
    checkOutput("relAec", 32'(aec_out), 32'd1);
    falls = 0; got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      applyStimulus(0, 1, 1);
      if (lastFall) falls++;
      if (cpu_dma_n === 1'b1) got = 1;
    end
    checkOutput("guardFalls", 32'(falls), 32'd1);
    repeat (5) applyStimulus(0, 1, 1);

    // Watchdog: one timeout pulse, then lockout while request stays low.
    tmoBefore = tmoSeen;
    repeat (300) applyStimulus(0, 0, 1);
    checkOutput("tmoPulses", 32'(tmoSeen - tmoBefore), 32'd1);
    checkOutput("lockoutOwner", 32'(bus_owner), 32'd0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);
    checkOutput("reRequest", 32'(bus_owner), 32'd1);

    // Release on the very clk a grant would occur: ack never rises.
    got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      if (grantOnNextEdge()) begin
        applyStimulus(0, 1, 1);
        got = 1;
      end else begin
        applyStimulus(0, 0, 1);
      end
    end
    checkOutput("raceFound", 32'(got), 32'd1);
    ackHigh = (dma_ack === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 1);
      if (dma_ack === 1'b1) ackHigh++;
    end
    checkOutput("raceNoAck", 32'(ackHigh), 32'd0);

    // Reset mid-grant.
    got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      applyStimulus(0, 0, 1);
      if (dma_ack === 1'b1) got = 1;
    end
    checkOutput("grant2Seen", 32'(got), 32'd1);
    applyStimulus(1, 0, 1);
    checkOutput("midRstAck", 32'(dma_ack), 32'd0);
    checkOutput("midRstDmaN", 32'(cpu_dma_n), 32'd1);
    checkOutput("midRstAec", 32'(aec_out), 32'd1);
    checkOutput("midRstOwner", 32'(bus_owner), 32'd0);
    repeat (5) applyStimulus(0, 1, 1);

    // Randomized traffic with VIC-II steals and occasional resets.
    reqLeft = 0; vicLeft = 0; rq = 1; vc = 1;
    for (int i = 0; i < 3000; i++) begin
      if (reqLeft == 0) begin
        rq = ~rq;
        reqLeft = rq ? $urandom_range(1, 30) : $urandom_range(5, 200);
      end
      reqLeft--;
      if (vicLeft == 0) begin
        vc = ~vc;
        vicLeft = vc ? $urandom_range(5, 60) : $urandom_range(1, 25);
      end
      vicLeft--;
      applyStimulus($urandom_range(0, 599) == 0, rq, vc);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
